uart_tx_fifo: RTL

Parametrised UART transmitter with an integrated transmit FIFO. It runs entirely in the system clock domain and times each bit with a clock-enable baud counter, so no derived clock is used. It serialises words in 8N1-style frames with configurable data width and stop-bit count, plus optional parity. It sits between the encoder datapath, which pushes words through a valid/ready handshake, and the board's serial TX pin.

---
 rtl/uart_tx_fifo.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO; bits are timed by a clock-enable baud counter.
// Define UART_TX_FIFO_PARITY_EN to add a parity bit after the data bits.
module uart_tx_fifo #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int N          = 8,
  parameter int STOP_BITS  = 1,
  parameter int DEPTH      = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           din,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic                   tx,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] level
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int BW  = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_FIFO_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state, state_next;
  logic [N-1:0]    mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level_next;
  logic [CW-1:0]   baud;
  logic [BW-1:0]   bit_idx;
  logic            stop_idx;
  logic [N-1:0]    shreg;
  logic            push, pop, bit_end;
  logic            tx_next, frame_end, frame_end_q;

  // Handshake: a word transfers on a rising edge where din_valid and din_ready are both high;
  // din_ready is a register derived from level only, so it never depends on this cycle's pop.
  assign push    = din_valid && din_ready;
  assign pop     = (state == S_IDLE) && (level != '0);
  assign bit_end = (baud == CW'(DIV - 1));

  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + 1'b1;
      2'b01:   level_next = level - 1'b1;
      default: level_next = level;
    endcase
  end

  // Storage is intentionally left uncleared by reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      din_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level     <= level_next;
      din_ready <= (level_next < LW'(DEPTH));
    end
  end

`ifdef UART_TX_FIFO_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk) begin
    if (pop) par_bit <= (^mem[rd_ptr]) ^ (PARITY_ODD != 0);
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  always_comb begin
    state_next = state;
    tx_next    = 1'b1;
    frame_end  = 1'b0;
    case (state)
      S_IDLE: begin
        if (pop) state_next = S_START;
      end
      S_START: begin
        tx_next = 1'b0;
        if (bit_end) state_next = S_DATA;
      end
      S_DATA: begin
        tx_next = shreg[0];
        if (bit_end && bit_idx == BW'(N - 1)) begin
`ifdef UART_TX_FIFO_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
        end
      end
`ifdef UART_TX_FIFO_PARITY_EN
      S_PARITY: begin
        tx_next = par_bit;
        if (bit_end) state_next = S_STOP;
      end
`endif
      S_STOP: begin
        tx_next = 1'b1;
        if (bit_end && stop_idx == 1'(STOP_BITS - 1)) begin
          state_next = S_IDLE;
          frame_end  = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Line outputs are registered from the current state, so tx trails the state by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      baud        <= '0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      tx          <= 1'b1;
      frame_end_q <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_IDLE || state_next != state || bit_end) baud <= '0;
      else baud <= baud + 1'b1;
      if (pop) begin
        shreg    <= mem[rd_ptr];
        bit_idx  <= '0;
        stop_idx <= 1'b0;
      end else if (state == S_DATA && bit_end) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + 1'b1;
      end else if (state == S_STOP && bit_end) begin
        stop_idx <= stop_idx + 1'b1;
      end
      tx          <= tx_next;
      frame_end_q <= frame_end;
      done        <= frame_end_q;
      busy        <= (state != S_IDLE) || (level != '0);
    end
  end
endmodule
